apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Upstream stage of the APB peripherals (timer, GPIO, UART, ...).
- Converts a simple CPU-side request/ready bus from the RISC-V core's data port into APB3 transfers.
- Decodes the address to one of NUM_SLAVES PSEL lines and muxes PRDATA/PREADY back.
- Bounds every transfer with a wait-state timeout so a stuck slave cannot hang the core.

Parameters:
- NUM_SLAVES, 4: number of APB slots / PSEL lines.
- BASE_ADDR, 32'h1000_0000: address of slot 0.
- SLOT_BITS, 12: log2 of slot size; slot k spans BASE_ADDR + k*2^SLOT_BITS.
- TIMEOUT, 16: maximum number of ACCESS cycles before forced termination. Range 2..255.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous active-high reset.
- req  in  1  CPU transfer request; level, held with addr/wdata/we stable until ready.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data.
- rdata  out  32  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready: decode error or timeout.
- PADDR  out  32  APB address (latched addr).
- PWDATA  out  32  APB write data.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES*32  slave read data, slot k at bits [32k+31:32k].
- PREADY  in  NUM_SLAVES  per-slave ready.

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous and active-high on PRESET, sampled at posedge PCLK.
- Reset state: IDLE. All outputs 0: rdata, ready, err, PADDR, PWDATA, PWRITE, PENABLE, PSEL.
- Reset mid-transfer abandons the transfer. PSEL/PENABLE are 0 from the next edge, and no ready is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - req is sampled only here.
  - On req=1, latch addr, wdata and we into PADDR/PWDATA/PWRITE and decode the address.
  - Hit on slot k: go to SETUP with sel_idx=k.
  - Miss (addr[31:SLOT_BITS] outside BASE_ADDR[31:SLOT_BITS] .. +NUM_SLAVES-1): go to DONE with err=1 and rdata=0. No PSEL is ever asserted.
- SETUP: PSEL[sel_idx]=1, PENABLE=0. Exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL[sel_idx]=1, PENABLE=1. wait_cnt increments each cycle, starting from 0.
  - If PREADY[sel_idx]=1: register rdata = PRDATA slot sel_idx (reads only; writes give rdata=0), set err=0, go to DONE.
  - Else if wait_cnt == TIMEOUT-1: go to DONE with err=1 and rdata=0.
  - PREADY of unselected slots is ignored.
- DONE:
  - ready=1 for exactly one cycle. rdata/err are valid this cycle.
  - PSEL=0 and PENABLE=0.
  - Next state is IDLE.
- Between transfers: rdata holds its value; err returns to 0 in IDLE.
- CPU obligation: drop req in the DONE cycle unless it wants another transfer. If req is still high in the following IDLE cycle, a new transfer starts.
- Latency, req sampled at cycle 0:
  - Zero-wait slave: ready at cycle 3.
  - Slave with registered PREADY (one wait state): ready at cycle 4.
  - Timeout: ready at cycle 1+TIMEOUT+1.
  - Decode error: ready at cycle 1.
- Back-to-back throughput: a new SETUP at the earliest 2 cycles after DONE (DONE, then IDLE sample).
- PADDR/PWDATA/PWRITE stay stable from SETUP through the last ACCESS cycle. They are not cleared in IDLE.
- Widths: wait_cnt is $clog2(TIMEOUT+1) bits and cannot wrap. sel_idx is $clog2(NUM_SLAVES) bits.

Decomposition:
- Package apb_pkg holds:
  - typedef enum logic [1:0] apb_state_t {IDLE, SETUP, ACCESS, DONE}.
  - localparam APB_DW = 32.
  - localparam APB_AW = 32.
- Sub-module apb_addr_decoder (combinational):
  - Inputs: addr, BASE_ADDR, SLOT_BITS, NUM_SLAVES.
  - Outputs: hit and sel_idx.
  - Reused later by the interconnect testbench.

Test Plan:
- Write with TIMEOUT=16; slot 1 is a timer-style slave with registered PREADY.
  - Stimulus: req, we=1, addr=0x1000_1008, wdata=100_000.
  - Response: PSEL=4'b0010 for cycles 1–3, PENABLE at cycles 2–3, PADDR=0x1000_1008, ready at cycle 4 with err=0. The slave reg at offset 8 reads 100_000.
- Read from slot 1:
  - Stimulus: addr=0x1000_1004 while the slave drives PRDATA1=0x0000_002A.
  - Response: rdata=0x2A at the ready cycle, err=0; other PSEL bits stay 0 throughout.
- Decode miss:
  - Stimulus: addr=0x1000_4000 with NUM_SLAVES=4.
  - Response: PSEL stays 4'b0000, ready=1 with err=1 and rdata=0 at cycle 1.
- Timeout:
  - Stimulus: slot 2 PREADY tied 0, TIMEOUT=16.
  - Response: PENABLE high for exactly 16 cycles, then ready=1 with err=1 and rdata=0. The FSM then accepts a new req.
- Back-to-back:
  - Stimulus: req held high across two transfers to slots 0 and 3 (zero-wait).
  - Response: the second SETUP starts 2 cycles after the first DONE; exactly two ready pulses; rdata matches each slave.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET for one cycle during ACCESS.
  - Response: PSEL, PENABLE, ready and err are 0 on the next edge; the state is IDLE; no spurious ready afterwards.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM state type and bus widths for the APB master bridge.
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_state_t;
    localparam int APB_DW = 32;
    localparam int APB_AW = 32;
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps a byte address onto one of NUM_SLAVES equal-sized slots.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int              NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR = 32'h1000_0000,
    parameter int              SLOT_BITS  = 12,
    localparam int             IW         = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1
) (
    input  logic [APB_AW-1:0] addr,
    output logic              hit,
    output logic [IW-1:0]     sel_idx
);
    logic [APB_AW-1:0] slot;
    // Addresses below the base wrap to a huge slot number and miss naturally.
    assign slot    = (addr >> SLOT_BITS) - (BASE_ADDR >> SLOT_BITS);
    assign hit     = slot < APB_AW'(NUM_SLAVES);
    assign sel_idx = slot[IW-1:0];
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: CPU req/ready bus to APB3 master with address decode and wait-state timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int                NUM_SLAVES = 4,
    parameter logic [APB_AW-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                SLOT_BITS  = 12,
    parameter int                TIMEOUT    = 16,
    localparam int               IW         = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1,
    localparam int               CW         = $clog2(TIMEOUT + 1)
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req,
    input  logic                         we,
    input  logic [APB_AW-1:0]            addr,
    input  logic [APB_DW-1:0]            wdata,
    output logic [APB_DW-1:0]            rdata,
    output logic                         ready,
    output logic                         err,
    output logic [APB_AW-1:0]            PADDR,
    output logic [APB_DW-1:0]            PWDATA,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*APB_DW-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY
);
    apb_state_t        state_q, state_d;
    logic [IW-1:0]     sel_q, sel_d, dec_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [APB_AW-1:0] paddr_q, paddr_d;
    logic [APB_DW-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic              pwrite_q, pwrite_d, err_q, err_d, dec_hit;
    logic [APB_DW-1:0] prd [NUM_SLAVES];

    apb_addr_decoder #(
        .NUM_SLAVES(NUM_SLAVES),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS)
    ) u_dec (
        .addr   (addr),
        .hit    (dec_hit),
        .sel_idx(dec_idx)
    );

    genvar g;
    for (g = 0; g < NUM_SLAVES; g++) begin : g_prd
        assign prd[g] = PRDATA[g*APB_DW +: APB_DW];
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (req) begin
                    paddr_d  = addr;
                    pwdata_d = wdata;
                    pwrite_d = we;
                    sel_d    = dec_idx;
                    err_d    = ~dec_hit;
                    rdata_d  = dec_hit ? rdata_q : '0;
                    state_d  = dec_hit ? SETUP : DONE;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY[sel_q]) begin
                    rdata_d = pwrite_q ? '0 : prd[sel_q];
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign PSEL    = (state_q == SETUP || state_q == ACCESS) ? NUM_SLAVES'(1) << sel_q : '0;
    assign PENABLE = state_q == ACCESS;
    assign ready   = state_q == DONE;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
endmodule
